// File: rtl/la_uart_uploader.sv
// la_uart_uploader: drains the capture FIFO into A5/LEN/payload packets on an 8N1 UART line; define LA_UPLOAD_CHKSUM_EN to append an XOR checksum frame
module la_uart_uploader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PKT_LEN = 16,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [CNT_W-1:0] fifo_rd_cnt,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [7:0]       fifo_rdata,
  output logic             uart_tx,
  output logic             busy,
  output logic             pkt_done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PKT_LEN);
`ifdef LA_UPLOAD_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CHK, DONE} state_t;
  logic [7:0] chk_q;
`else
  typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, DONE} state_t;
`endif
  state_t state, state_n;
  logic [BW-1:0] baud_cnt;
  logic [3:0] bit_idx;
  logic [7:0] len_q, len_n, pay_idx, data_q, cur_byte;
  logic flush_pend, ren_q, in_frame, bit_end, frame_end, last_pay;
  logic start_full, start_flush, start, rd_slot;
  assign in_frame = state != IDLE && state != DONE;
  assign bit_end = baud_cnt == BAUD_MAX;
  assign frame_end = in_frame && bit_end && bit_idx == 4'd9;
  assign last_pay = pay_idx == len_q - 8'd1;
  assign start_full = enable && fifo_rd_cnt >= FULL;
  assign start_flush = flush_pend && fifo_rd_cnt != '0 && fifo_rd_cnt < FULL;
  assign start = state == IDLE && (start_full || start_flush);
  assign len_n = start_full ? 8'(PKT_LEN) : 8'(fifo_rd_cnt);
  // data_q is refilled during each stop bit, after the current byte's data bits are already out
  assign rd_slot = bit_idx == 4'd9 && baud_cnt == '0 && (state == HDR || (state == PAY && !last_pay));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? HDR : IDLE;
      HDR: state_n = frame_end ? LEN : HDR;
      LEN: state_n = frame_end ? PAY : LEN;
`ifdef LA_UPLOAD_CHKSUM_EN
      PAY: state_n = frame_end && last_pay ? CHK : PAY;
      CHK: state_n = frame_end ? DONE : CHK;
`else
      PAY: state_n = frame_end && last_pay ? DONE : PAY;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
`ifdef LA_UPLOAD_CHKSUM_EN
    cur_byte = state == HDR ? 8'hA5 : state == LEN ? len_q : state == PAY ? data_q : chk_q;
`else
    cur_byte = state == HDR ? 8'hA5 : state == LEN ? len_q : data_q;
`endif
    uart_tx = !in_frame || bit_idx == 4'd9 ? 1'b1 : bit_idx == 4'd0 ? 1'b0 : cur_byte[3'(bit_idx - 4'd1)];
    busy = in_frame;
    pkt_done = state == DONE;
    fifo_ren = rd_slot && !fifo_empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx <= '0;
      len_q <= '0;
      pay_idx <= '0;
      data_q <= '0;
      ren_q <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      baud_cnt <= in_frame && !bit_end ? baud_cnt + 1'b1 : '0;
      bit_idx <= !in_frame || frame_end ? 4'd0 : bit_end ? bit_idx + 4'd1 : bit_idx;
      pay_idx <= state == IDLE ? 8'd0 : state == PAY && frame_end ? pay_idx + 8'd1 : pay_idx;
      if (start) len_q <= len_n;
      ren_q <= fifo_ren;
      if (ren_q) data_q <= fifo_rdata;
      flush_pend <= (flush || flush_pend) && fifo_rd_cnt != '0 && !(start && !start_full);
    end
`ifdef LA_UPLOAD_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_q <= '0;
    else if (start) chk_q <= len_n;
    else if (ren_q) chk_q <= chk_q ^ fifo_rdata;
`endif
endmodule

// File: tb/tb_la_uart_uploader.sv
// tb_la_uart_uploader: FIFO model, UART decoder scoreboard and per-scenario tasks for la_uart_uploader
module tb_la_uart_uploader;
  localparam int CPB = 4, PL = 4, CW = 10, FRAME = 10 * CPB;
`ifdef LA_UPLOAD_CHKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0, fifo_empty = 1'b1;
  logic fifo_ren, uart_tx, busy, pkt_done;
  logic [CW-1:0] fifo_rd_cnt = '0;
  logic [7:0] fifo_rdata = '0;
  byte unsigned fifo_q[$], exp_q[$];
  int total = 0, bad = 0;
  int busy_cnt = 0, ren_cnt = 0, ren_empty = 0, pd_cnt = 0, idle_low = 0, rise_bad = 0;
  int idle_run = 0, gap_min = 1000000;
  logic prev_busy = 1'b0, ren_lat = 1'b0, rst_seen = 1'b0, rx_stp;
  logic [7:0] rx_b, rx_e;
  always #5 clk = ~clk;
  la_uart_uploader #(.CLKS_PER_BIT(CPB), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_rd_cnt(fifo_rd_cnt), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata), .uart_tx(uart_tx), .busy(busy), .pkt_done(pkt_done)
  );
  always @(posedge clk) begin
    if (ren_lat && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    fifo_rd_cnt <= CW'(fifo_q.size());
    fifo_empty <= fifo_q.size() == 0;
  end
  always @(negedge clk) begin
    ren_lat = fifo_ren;
    if (fifo_ren) ren_cnt++;
    if (fifo_ren && fifo_empty) ren_empty++;
    if (busy) busy_cnt++;
    if (pkt_done) pd_cnt++;
    if (rst_n && !busy && uart_tx !== 1'b1) idle_low++;
    if (busy && !prev_busy) begin
      if (uart_tx !== 1'b0) rise_bad++;
      if (pd_cnt > 0 && idle_run < gap_min) gap_min = idle_run;
    end
    idle_run = busy ? 0 : idle_run + 1;
    prev_busy = busy;
  end
  always @(negedge rst_n) rst_seen = 1'b1;
  initial forever begin
    @(negedge clk);
    if (rst_n && uart_tx === 1'b0) begin
      rst_seen = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      rx_stp = uart_tx;
      if (!rst_seen) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_byte: got %02h stop %0b, required no frame", rx_b, rx_stp);
        end else begin
          rx_e = exp_q.pop_front();
          if (rx_b !== rx_e || rx_stp !== 1'b1) begin
            bad++;
            $display("FAIL rx_byte: got %02h stop %0b, required %02h stop 1", rx_b, rx_stp, rx_e);
          end
        end
      end
    end
  end
  task automatic expect_pkt(input byte unsigned d[$]);
    byte unsigned chk = 8'(d.size());
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(d.size()));
    foreach (d[i]) begin
      exp_q.push_back(d[i]);
      chk ^= d[i];
    end
    if (C == 1) exp_q.push_back(chk);
  endtask
  task automatic wait_pkts(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = pd_cnt >= n;
    end
  endtask
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = busy;
    end
  endtask
  task automatic pulse_flush;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (fifo_ren !== 1'b0) begin bad++; $display("FAIL reset_ren: got %b, required 0", fifo_ren); end
    total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", pkt_done); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_full;
    byte unsigned d[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int b0 = busy_cnt, r0 = ren_cnt, p0 = pd_cnt;
    bit ok;
    foreach (d[i]) fifo_q.push_back(d[i]);
    expect_pkt(d);
    enable = 1'b1;
    wait_pkts(p0 + 1, 1000, ok);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout: got no pkt_done, required one"); end
    total++; if (busy_cnt - b0 != (6 + C) * FRAME) begin bad++; $display("FAIL full_busy: got %0d, required %0d", busy_cnt - b0, (6 + C) * FRAME); end
    total++; if (ren_cnt - r0 != 4) begin bad++; $display("FAIL full_ren: got %0d, required 4", ren_cnt - r0); end
    total++; if (pd_cnt - p0 != 1) begin bad++; $display("FAIL full_done: got %0d, required 1", pd_cnt - p0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_rx_left: got %0d, required 0", exp_q.size()); end
  endtask
  task automatic test_flush;
    byte unsigned d[$] = '{8'h0F, 8'hF0};
    byte unsigned one[$] = '{8'h5A};
    int b0 = busy_cnt, p0 = pd_cnt;
    bit ok;
    foreach (d[i]) fifo_q.push_back(d[i]);
    repeat (20) @(negedge clk);
    total++; if (busy_cnt != b0) begin bad++; $display("FAIL flush_nostart: got %0d busy cycles, required 0", busy_cnt - b0); end
    expect_pkt(d);
    pulse_flush;
    wait_pkts(p0 + 1, 1000, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL flush_timeout: got no pkt_done, required one"); end
    total++; if (busy_cnt - b0 != (4 + C) * FRAME) begin bad++; $display("FAIL flush_busy: got %0d, required %0d", busy_cnt - b0, (4 + C) * FRAME); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flush_rx_left: got %0d, required 0", exp_q.size()); end
    b0 = busy_cnt;
    p0 = pd_cnt;
    pulse_flush;
    repeat (50) @(negedge clk);
    fifo_q.push_back(8'h5A);
    repeat (100) @(negedge clk);
    total++; if (busy_cnt != b0) begin bad++; $display("FAIL flush_empty: got %0d busy cycles, required 0", busy_cnt - b0); end
    expect_pkt(one);
    pulse_flush;
    wait_pkts(p0 + 1, 1000, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || busy_cnt - b0 != (3 + C) * FRAME) begin bad++; $display("FAIL flush_len1: got %0d busy cycles, required %0d", busy_cnt - b0, (3 + C) * FRAME); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flush_len1_rx: got %0d left, required 0", exp_q.size()); end
  endtask
  task automatic test_back_to_back;
    byte unsigned a[$], b[$];
    int r0 = ren_cnt, p0 = pd_cnt;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      byte unsigned v = 8'($urandom_range(0, 255));
      fifo_q.push_back(v);
      if (i < 4) a.push_back(v);
      else b.push_back(v);
    end
    expect_pkt(a);
    expect_pkt(b);
    enable = 1'b1;
    wait_pkts(p0 + 2, 2000, ok);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d packets, required 2", pd_cnt - p0); end
    total++; if (ren_cnt - r0 != 8) begin bad++; $display("FAIL b2b_ren: got %0d, required 8", ren_cnt - r0); end
    total++; if (ren_empty != 0) begin bad++; $display("FAIL b2b_ren_empty: got %0d, required 0", ren_empty); end
    total++; if (gap_min < 1) begin bad++; $display("FAIL b2b_gap: got %0d, required >=1", gap_min); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_rx_left: got %0d, required 0", exp_q.size()); end
  endtask
  task automatic test_enable_drop;
    byte unsigned a[$];
    int r0 = ren_cnt, p0 = pd_cnt;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      byte unsigned v = 8'($urandom_range(0, 255));
      fifo_q.push_back(v);
      if (i < 4) a.push_back(v);
    end
    expect_pkt(a);
    enable = 1'b1;
    wait_busy(ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_start: got busy 0, required 1"); end
    repeat (3 * FRAME + 10) @(negedge clk);
    enable = 1'b0;
    wait_pkts(p0 + 1, 1000, ok);
    repeat (300) @(negedge clk);
    total++; if (pd_cnt - p0 != 1) begin bad++; $display("FAIL drop_pkts: got %0d, required 1", pd_cnt - p0); end
    total++; if (fifo_q.size() != 4) begin bad++; $display("FAIL drop_left: got %0d, required 4", fifo_q.size()); end
    total++; if (ren_cnt - r0 != 4) begin bad++; $display("FAIL drop_ren: got %0d, required 4", ren_cnt - r0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drop_rx_left: got %0d, required 0", exp_q.size()); end
  endtask
  task automatic test_reset_mid_frame;
    byte unsigned d[$];
    int r0 = ren_cnt, b0, p0;
    bit ok;
    exp_q.push_back(8'hA5);
    enable = 1'b1;
    wait_busy(ok);
    repeat (FRAME + 12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b, required 1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b0 = busy_cnt;
    p0 = pd_cnt;
    repeat (200) @(negedge clk);
    total++; if (busy_cnt != b0 || pd_cnt != p0) begin bad++; $display("FAIL rstmid_idle: got %0d busy cycles, required 0", busy_cnt - b0); end
    total++; if (ren_cnt - r0 != 1) begin bad++; $display("FAIL rstmid_ren: got %0d, required 1", ren_cnt - r0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_hdr: got %0d left, required 0", exp_q.size()); end
    d = fifo_q;
    expect_pkt(d);
    pulse_flush;
    wait_pkts(p0 + 1, 1000, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || busy_cnt - b0 != (2 + d.size() + C) * FRAME) begin bad++; $display("FAIL rstmid_drain: got %0d busy cycles, required %0d", busy_cnt - b0, (2 + d.size() + C) * FRAME); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_rx_left: got %0d, required 0", exp_q.size()); end
  endtask
  initial begin
    test_reset;
    test_full;
    test_flush;
    test_back_to_back;
    test_enable_drop;
    test_reset_mid_frame;
    total++; if (idle_low != 0) begin bad++; $display("FAIL idle_line: got %0d low idle cycles, required 0", idle_low); end
    total++; if (rise_bad != 0) begin bad++; $display("FAIL busy_rise: got %0d rises without start bit, required 0", rise_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/la_uart_uploader.md
# la_uart_uploader

Drains the logic-analyzer capture FIFO, which holds packed 2-channel sample bytes, 4 samples per channel per byte. Frames the bytes into length-prefixed packets and transmits them on an 8N1 UART line to the host. Sits directly downstream of the capture stage's FIFO and is the only reader of that FIFO.

## Interface
- `CLKS_PER_BIT`, default 87: clk cycles per UART bit (87 gives 576000 baud at 50 MHz).
- `PKT_LEN`, default 16: maximum payload bytes per packet, range 1..255.
- `CNT_W`, default 10: width of the FIFO read-count input.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: level. When high, new packets may start.
- `flush`  in  1: one-cycle pulse. Requests a short packet of whatever is buffered.
- `fifo_rd_cnt`  in  CNT_W: bytes currently readable in the FIFO.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_ren`  out  1: read strobe, one-cycle pulses.
- `fifo_rdata`  in  8: read data, valid the cycle after `fifo_ren`.
- `uart_tx`  out  1: serial output, idles high.
- `busy`  out  1: high from packet start through the end of the last stop bit.
- `pkt_done`  out  1: one-cycle pulse on the cycle after the last stop bit completes.

## Operation
- Packet format, in transmit order: 0xA5, LEN, LEN payload bytes, then CHK (only when configured). LEN is 1..PKT_LEN.
- UART frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, HDR, LEN, PAY, CHK, DONE.
- IDLE to HDR when `enable` is high and `fifo_rd_cnt >= PKT_LEN`. LEN is latched as PKT_LEN.
- IDLE to HDR when a flush is pending and `0 < fifo_rd_cnt < PKT_LEN`. LEN is latched as `fifo_rd_cnt`. This path starts even if `enable` is low.
- A flush pulse sets a pending flag. The flag clears when the flushed packet starts. It also clears immediately if `fifo_rd_cnt` is 0.
- HDR, LEN and PAY each send one byte. PAY repeats LEN times. After the last payload byte the FSM goes to CHK if configured, otherwise to DONE.
- DONE lasts one cycle, pulses `pkt_done`, and returns to IDLE.
- Payload prefetch:
  - The read for payload byte 0 is issued during the HDR frame.
  - The read for byte k+1 is issued during the transmission of byte k.
  - Exactly LEN `fifo_ren` pulses occur per packet.
- `fifo_ren` is never asserted while `fifo_empty` is high. The LEN latch guarantees data is present because this block is the sole reader.
- Mid-packet `enable` deassertion: the current packet completes, then the block stays in IDLE.
- A flush arriving mid-packet stays pending and is evaluated in IDLE.
- Reset values, all outputs: `uart_tx`=1, `fifo_ren`=0, `busy`=0, `pkt_done`=0. FSM=IDLE, flush-pending=0, bit counter=0, baud counter=0.
- Reset mid-frame: `uart_tx` returns high asynchronously. No further reads are issued. Bytes already read are discarded.

## Timing
- The start bit of the 0xA5 header begins on the cycle after the IDLE to HDR decision.
- `busy` rises on the same cycle as the header start bit.
- Frames within a packet are back-to-back, with zero idle cycles between stop bit and next start bit.
- Packet duration is (2 + LEN + C) × 10 × CLKS_PER_BIT cycles, where C is 1 with checksum and 0 without. `pkt_done` follows on the next cycle.
- At least one cycle of IDLE separates packets, so the line is high for ≥1 cycle.
- `fifo_ren` for each payload byte occurs at least 2 cycles before that byte's start bit.
- The baud counter counts 0..CLKS_PER_BIT−1 and wraps. The bit index counts 0..9. Widths come from `$clog2`.

## Configuration
- `LA_UPLOAD_CHKSUM_EN` defined: CHK state present. CHK = XOR of LEN and all payload bytes, sent as one extra frame after the last payload byte.
- `LA_UPLOAD_CHKSUM_EN` undefined: no CHK state and no checksum logic. Packets end after the last payload byte.

## Test plan
All scenarios use CLKS_PER_BIT=4 and PKT_LEN=4.
- Full packet, checksum off: preload FIFO with 11,22,33,44, set `enable`=1. Line decodes A5,04,11,22,33,44. 240 busy cycles, exactly 4 `fifo_ren` pulses, then `pkt_done`.
- Checksum on: same stimulus. Line decodes A5,04,11,22,33,44,CHK with CHK=0x40 (04^11^22^33^44). 280 busy cycles.
- Flush: 2 bytes 0x0F,0xF0 in FIFO, `enable`=0, pulse `flush`. Line decodes A5,02,0F,F0. A flush with an empty FIFO produces no packet and the line stays high.
- Back-to-back: 8 bytes preloaded. Two consecutive packets, each LEN=4. Line high ≥1 cycle between them. No `fifo_ren` while `fifo_empty`=1.
- Enable drop: deassert `enable` during the second payload frame. The packet completes normally, then no new packet starts although 4 bytes remain.
- Reset mid-frame: assert `rst_n`=0 during a data bit. `uart_tx`=1 and `busy`=0 immediately. After release, the block is idle until a start condition occurs.
